bin_pixel_packer: RTL and testbench
===================================

BIN_PIXEL_PACKER -- requirements
Module: bin_pixel_packer

Interface
REQ-001 SHALL have parameter PACK_WIDTH, default 16: binary pixels per packed word.
REQ-002 SHALL have parameter WORDS_PER_FRAME, default 19200: expected words per 640x480 frame.
REQ-003 SHALL have port CCD_PIXCLK  in  1  pixel clock; all logic on rising edge.
REQ-004 SHALL have port DLY_RST_1  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iFVAL  in  1  registered camera frame-valid.
REQ-006 SHALL have port iDVAL  in  1  binary pixel valid from the threshold stage.
REQ-007 SHALL have port iBIT  in  1  thresholded pixel value.
REQ-008 SHALL have port iFIFO_FULL  in  1  SDRAM write-FIFO full.
REQ-009 SHALL have port iCLR_ERR  in  1  synchronous clear of sticky error flags.
REQ-010 SHALL have port oWORD  out  PACK_WIDTH  packed word; first pixel in bit 0.
REQ-011 SHALL have port oWR  out  1  one-cycle write strobe for oWORD.
REQ-012 SHALL have port oFRAME_DONE  out  1  one-cycle end-of-frame pulse.
REQ-013 SHALL have port oWORD_CNT  out  15  words emitted in current/last frame.
REQ-014 SHALL have port oOVERFLOW  out  1  sticky: a word was strobed while FIFO full.
REQ-015 SHALL have port oSHORT_FRAME  out  1  last completed frame word count != WORDS_PER_FRAME.

Function
REQ-016 SHALL implement states SYNC, IDLE, PACK, DONE.
REQ-017 SYNC -> IDLE when iFVAL=0; frames in progress at reset release are ignored.
REQ-018 IDLE -> PACK when iFVAL=1; on entry bit index, accumulator and oWORD_CNT clear to 0.
REQ-019 In PACK a pixel is accepted only when iFVAL=1 and iDVAL=1; accumulator[bit index] <= iBIT, bit index increments.
REQ-020 On acceptance of pixel PACK_WIDTH of a word (cycle N), oWORD SHALL hold the word and oWR=1 in cycle N+1 only; accumulator and bit index clear to 0 so the next pixel (N+1) starts a fresh word.
REQ-021 PACK -> DONE in the cycle iFVAL=0 is sampled; iDVAL in that cycle is ignored.
REQ-022 DONE SHALL last exactly one cycle with oFRAME_DONE=1; if bit index was k>0, oWR=1 in the same cycle with bits [k-1:0] valid and bits above zero-padded.
REQ-023 DONE -> IDLE unconditionally; pixels presented during DONE are dropped.
REQ-024 oWORD_CNT SHALL increment on every oWR, saturating at 32767.
REQ-025 On oFRAME_DONE, oSHORT_FRAME SHALL update to (final count != WORDS_PER_FRAME); it holds until the next frame completes.
REQ-026 If iFIFO_FULL=1 in a cycle with oWR=1, the word is still counted, oOVERFLOW SHALL set and stay 1 until iCLR_ERR=1 or reset.
REQ-027 iCLR_ERR SHALL clear oOVERFLOW and oSHORT_FRAME next cycle; a simultaneous set event wins.
REQ-028 oWORD SHALL hold its last value when oWR=0.

Reset
REQ-029 On DLY_RST_1=0, at any time including mid-frame: state SYNC; oWORD, oWR, oFRAME_DONE, oWORD_CNT, oOVERFLOW, oSHORT_FRAME, accumulator, bit index all 0.
REQ-030 A partial word in progress at reset SHALL be discarded, never written.

Structure
REQ-031 PACK_WIDTH default, WORDS_PER_FRAME default, and the state enumeration SHALL live in shared package pixel_pack_pkg.
REQ-032 SHALL be a single module with no sub-module; all outputs registered.

Verification
REQ-033 Frame start, 16 accepted pixels 1,0,1,0,... -> oWR=1 one cycle after the 16th pixel, oWORD=16'h5555, oWORD_CNT=1.
REQ-034 Full 640x480 frame with all iBIT=1 -> 19200 strobes of 16'hFFFF, then oFRAME_DONE with no oWR, oWORD_CNT=19200, oSHORT_FRAME=0.
REQ-035 Frame of 20 pixels, all 1 -> 16'hFFFF strobe, then oWR with 16'h000F in the oFRAME_DONE cycle, oWORD_CNT=2, oSHORT_FRAME=1.
REQ-036 iFIFO_FULL=1 during a strobe -> oOVERFLOW=1, held through the next frame; iCLR_ERR pulse -> 0 next cycle.
REQ-037 Reset after 7 pixels with iFVAL still 1, then release -> all outputs 0, no oWR and no oFRAME_DONE until iFVAL goes 0 then 1; next word starts at bit 0.
REQ-038 iDVAL=1 with iFVAL=0 inside and outside a frame -> no accumulator change, no oWR.

Source files
------------

// File: rtl/pixel_pack_pkg.sv
// Shared constants for the binary pixel packer: default geometry and FSM state codes.
package pixel_pack_pkg;

    // Binary pixels packed into one SDRAM word.
    localparam int PP_PACK_WIDTH      = 16;
    // Words in a 640x480 frame at 16 pixels per word.
    localparam int PP_WORDS_PER_FRAME = 19200;

    // Packer FSM state encoding.
    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_PACK = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/bin_pixel_packer.sv
// Packs thresholded camera pixels into PACK_WIDTH-bit words (first pixel in bit 0),
// strobes each word toward the SDRAM write FIFO and tracks per-frame word count
// plus sticky overflow / short-frame status.
module bin_pixel_packer
    import pixel_pack_pkg::*;
#(
    parameter int PACK_WIDTH      = PP_PACK_WIDTH,
    parameter int WORDS_PER_FRAME = PP_WORDS_PER_FRAME
) (
    input  logic                  CCD_PIXCLK,
    input  logic                  DLY_RST_1,
    input  logic                  iFVAL,
    input  logic                  iDVAL,
    input  logic                  iBIT,
    input  logic                  iFIFO_FULL,
    input  logic                  iCLR_ERR,
    output logic [PACK_WIDTH-1:0] oWORD,
    output logic                  oWR,
    output logic                  oFRAME_DONE,
    output logic [14:0]           oWORD_CNT,
    output logic                  oOVERFLOW,
    output logic                  oSHORT_FRAME
);

    localparam int               IDX_W    = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_WIDTH - 1);
    localparam logic [14:0]      CNT_MAX  = 15'h7FFF;
    localparam logic [14:0]      CNT_FULL = 15'(WORDS_PER_FRAME);

    // Word counter increment that sticks at the 15-bit ceiling.
    function automatic logic [14:0] sat_inc(input logic [14:0] c);
        return (c == CNT_MAX) ? c : c + 15'd1;
    endfunction

    logic [1:0]            state;
    logic [IDX_W-1:0]      bit_idx;
    logic [PACK_WIDTH-1:0] acc;
    logic [PACK_WIDTH-1:0] acc_with_bit;
    logic                  accept;
    logic                  word_full;
    logic                  frame_end;
    logic                  flush;
    logic [14:0]           final_cnt;

    assign accept    = (state == ST_PACK) && iFVAL && iDVAL;
    assign word_full = accept && (bit_idx == LAST_IDX);
    // The iFVAL=0 cycle closes the frame; iDVAL in that cycle is deliberately ignored.
    assign frame_end = (state == ST_PACK) && !iFVAL;
    assign flush     = frame_end && (bit_idx != '0);
    assign final_cnt = flush ? sat_inc(oWORD_CNT) : oWORD_CNT;

    // Accumulator with the current pixel merged in at the active bit position.
    always_comb begin
        acc_with_bit          = acc;
        acc_with_bit[bit_idx] = iBIT;
    end

    // Frame FSM, pixel accumulation, word strobes and word counting.
    always_ff @(posedge CCD_PIXCLK or negedge DLY_RST_1) begin
        if (!DLY_RST_1) begin
            state       <= ST_SYNC;
            bit_idx     <= '0;
            acc         <= '0;
            oWORD       <= '0;
            oWR         <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oWORD_CNT   <= '0;
        end else begin
            oWR         <= 1'b0;
            oFRAME_DONE <= 1'b0;
            case (state)
                ST_SYNC: begin
                    // Wait out any frame already running when reset released.
                    if (!iFVAL) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (iFVAL) begin
                        state     <= ST_PACK;
                        bit_idx   <= '0;
                        acc       <= '0;
                        oWORD_CNT <= '0;
                    end
                end
                ST_PACK: begin
                    if (frame_end) begin
                        // Partial word leaves with its upper bits still zero from the fresh start.
                        state       <= ST_DONE;
                        oFRAME_DONE <= 1'b1;
                        bit_idx     <= '0;
                        acc         <= '0;
                        if (flush) begin
                            oWORD     <= acc;
                            oWR       <= 1'b1;
                            oWORD_CNT <= sat_inc(oWORD_CNT);
                        end
                    end else if (word_full) begin
                        oWORD     <= acc_with_bit;
                        oWR       <= 1'b1;
                        oWORD_CNT <= sat_inc(oWORD_CNT);
                        bit_idx   <= '0;
                        acc       <= '0;
                    end else if (accept) begin
                        acc     <= acc_with_bit;
                        bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
                default: begin
                    // DONE lasts one cycle; pixels arriving now are dropped.
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky status flags; a set event in the same cycle as a clear wins.
    always_ff @(posedge CCD_PIXCLK or negedge DLY_RST_1) begin
        if (!DLY_RST_1) begin
            oOVERFLOW    <= 1'b0;
            oSHORT_FRAME <= 1'b0;
        end else begin
            if (oWR && iFIFO_FULL) oOVERFLOW <= 1'b1;
            else if (iCLR_ERR)     oOVERFLOW <= 1'b0;

            if (frame_end)     oSHORT_FRAME <= (final_cnt != CNT_FULL);
            else if (iCLR_ERR) oSHORT_FRAME <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bin_pixel_packer.sv
// Directed bench for bin_pixel_packer; frame length scaled to 640 pixels (40 words).
module tb_bin_pixel_packer;

    localparam int PW  = 16;
    localparam int WPF = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fval = 1'b0;
    logic          dval = 1'b0;
    logic          pix = 1'b0;
    logic          fifo_full = 1'b0;
    logic          clr_err = 1'b0;
    logic [PW-1:0] word;
    logic          wr;
    logic          frame_done;
    logic [14:0]   word_cnt;
    logic          overflow;
    logic          short_frame;

    int checks = 0;
    int errors = 0;

    bin_pixel_packer #(.PACK_WIDTH(PW), .WORDS_PER_FRAME(WPF)) dut (
        .CCD_PIXCLK  (clk),
        .DLY_RST_1   (rst_n),
        .iFVAL       (fval),
        .iDVAL       (dval),
        .iBIT        (pix),
        .iFIFO_FULL  (fifo_full),
        .iCLR_ERR    (clr_err),
        .oWORD       (word),
        .oWR         (wr),
        .oFRAME_DONE (frame_done),
        .oWORD_CNT   (word_cnt),
        .oOVERFLOW   (overflow),
        .oSHORT_FRAME(short_frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic f, input logic d, input logic b);
        fval = f;
        dval = d;
        pix  = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int strobes;
        int bad_words;
        int stray;

        // Reset state
        #12;
        check("rst_word", word, 0);
        check("rst_wr", wr, 0);
        check("rst_done", frame_done, 0);
        check("rst_cnt", word_cnt, 0);
        check("rst_ovf", overflow, 0);
        check("rst_short", short_frame, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // SYNC -> IDLE, then iDVAL with iFVAL=0 outside a frame
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1);
            if (wr || frame_done) stray++;
        end
        check("idle_dval_no_wr", stray, 0);

        // 16 pixels 1,0,1,0,... -> 16'h5555
        step(1, 0, 0);
        stray = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, 1, (i % 2) == 0);
            if (i < 15 && wr) stray++;
        end
        check("alt_early_wr", stray, 0);
        check("alt_wr", wr, 1);
        check("alt_word", word, 16'h5555);
        check("alt_cnt", word_cnt, 1);
        step(1, 0, 0);
        check("alt_wr_one_cycle", wr, 0);
        check("alt_word_hold", word, 16'h5555);
        // three more pixels, then end of frame with iDVAL=1 (ignored)
        step(1, 1, 1);
        step(1, 1, 1);
        step(1, 1, 1);
        step(0, 1, 1);
        check("part_done", frame_done, 1);
        check("part_wr", wr, 1);
        check("part_word", word, 16'h0007);
        check("part_cnt", word_cnt, 2);
        check("part_short", short_frame, 1);
        step(0, 1, 1);
        check("done_one_cycle", frame_done, 0);
        check("done_drop_wr", wr, 0);
        step(0, 0, 0);

        // FIFO full with no strobe must not flag overflow
        fifo_full = 1'b1;
        step(0, 0, 0);
        check("full_no_wr_ovf", overflow, 0);
        fifo_full = 1'b0;

        // 20-pixel frame, all 1, with FIFO full during the first strobe
        step(1, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 1, 1);
        check("f20_wr", wr, 1);
        check("f20_word", word, 16'hFFFF);
        fifo_full = 1'b1;
        step(1, 1, 1);
        fifo_full = 1'b0;
        check("f20_ovf_set", overflow, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 1);
        step(0, 0, 0);
        check("f20_done", frame_done, 1);
        check("f20_tail_wr", wr, 1);
        check("f20_tail_word", word, 16'h000F);
        check("f20_cnt", word_cnt, 2);
        check("f20_short", short_frame, 1);
        step(0, 0, 0);

        // Exact-length frame: 640 pixels of 1 -> 40 strobes of 16'hFFFF
        step(1, 0, 0);
        strobes   = 0;
        bad_words = 0;
        for (int i = 0; i < WPF * PW; i++) begin
            step(1, 1, 1);
            if (wr) begin
                strobes++;
                if (word != 16'hFFFF) bad_words++;
            end
        end
        check("full_strobes", strobes, WPF);
        check("full_bad_words", bad_words, 0);
        step(0, 0, 0);
        check("full_done", frame_done, 1);
        check("full_done_no_wr", wr, 0);
        check("full_cnt", word_cnt, WPF);
        check("full_short", short_frame, 0);
        check("ovf_held", overflow, 1);
        step(0, 0, 0);

        // Clear pulse drops the sticky overflow next cycle
        clr_err = 1'b1;
        step(0, 0, 0);
        clr_err = 1'b0;
        check("clr_ovf", overflow, 0);

        // Reset mid-frame after 7 pixels, released with iFVAL still high
        step(1, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 1, 1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_cnt", word_cnt, 0);
        check("mid_rst_word", word, 0);
        check("mid_rst_wr", wr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 24; i++) begin
            step(1, 1, 1);
            if (wr || frame_done) stray++;
        end
        check("sync_ignores_frame", stray, 0);
        step(0, 0, 0);
        check("sync_exit_no_done", frame_done, 0);
        step(1, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 1, i == 0);
        check("post_rst_wr", wr, 1);
        check("post_rst_word", word, 16'h0001);
        check("post_rst_cnt", word_cnt, 1);

        // iDVAL with iFVAL=0 inside a frame: only the frame end, no pixel taken
        step(1, 1, 1);
        step(0, 1, 1);
        check("in_frame_fval0_word", word, 16'h0001);
        check("in_frame_fval0_cnt", word_cnt, 2);
        step(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
